// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data memory responder and its storage bank:
//   - dmem_state_e : responder FSM states (IDLE, WAIT, ACCESS, RESP)
//   - BYTE_WIDTH   : bits per byte lane
//   - LANES        : byte lanes per 32-bit word
//   - WAIT_CNT_W   : width of the wait-state counter
//   - align_right  : shifts a word down to the addressed byte, zero-filling
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dmem_state_e;

  localparam int BYTE_WIDTH = 8;
  localparam int LANES      = 4;
  localparam int WAIT_CNT_W = 4;

  // Right-align a word to the byte selected by byte_off, zero-filled from the top.
  function automatic logic [31:0] align_right(input logic [31:0] word,
                                              input logic [1:0]  byte_off);
    logic [31:0] res;
    case (byte_off)
      2'd0:    res = word;
      2'd1:    res = {8'h00, word[31:8]};
      2'd2:    res = {16'h0000, word[31:16]};
      default: res = {24'h000000, word[31:24]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// -----------------------------------------------------------------------------
// dmem_sram_bank
// Word storage built from four byte-wide lane arrays. Each lane has its own
// synchronous write enable; the read port is synchronous and returns the full
// word one cycle after rd_en_i. Contents are never reset.
// Ports:
//   clk        rising-edge clock
//   wr_en_i    per-lane write enables (bit i -> bits 8i+7:8i)
//   wr_idx_i   word index for writes
//   wr_data_i  write data, lane-aligned
//   rd_en_i    capture a word read this cycle
//   rd_idx_i   word index for reads
//   rd_data_o  last captured read word
// -----------------------------------------------------------------------------
module dmem_sram_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                          clk,
  input  logic [LANES-1:0]              wr_en_i,
  input  logic [$clog2(DEPTH)-1:0]      wr_idx_i,
  input  logic [LANES*BYTE_WIDTH-1:0]   wr_data_i,
  input  logic                          rd_en_i,
  input  logic [$clog2(DEPTH)-1:0]      rd_idx_i,
  output logic [LANES*BYTE_WIDTH-1:0]   rd_data_o
);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [BYTE_WIDTH-1:0] lane_mem [DEPTH];
    logic [BYTE_WIDTH-1:0] rd_q;

    // Per-lane synchronous write and synchronous read capture.
    always_ff @(posedge clk) begin
      if (wr_en_i[g]) begin
        lane_mem[wr_idx_i] <= wr_data_i[g*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (rd_en_i) begin
        rd_q <= lane_mem[rd_idx_i];
      end
    end

    assign rd_data_o[g*BYTE_WIDTH +: BYTE_WIDTH] = rd_q;
  end

endmodule

// File: rtl/data_memory_responder.sv
// -----------------------------------------------------------------------------
// data_memory_responder
// Memory-side responder for the load/store path. Accepts one request at a
// time, optionally waits WAIT_STATES cycles, then performs a lane-masked write
// or a right-aligned word read, and pulses response_valid for one cycle.
// Optional feature macro: DMEM_FAULT_EN adds the fault output, flagging
// out-of-range accesses, writes with an empty mask and requests with no op.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   request_valid    request present
//   request_ready    responder idle and able to accept
//   memory_read      load request (wins over memory_write)
//   memory_write     store request
//   address          byte address
//   write_data       store data, replicated across lanes
//   write_mask       byte-lane write enables
//   response_valid   one-cycle completion pulse
//   read_data        load result, held until the next read or no-op
//   fault            (DMEM_FAULT_EN only) error flag, valid with response_valid
// -----------------------------------------------------------------------------
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH        = 1024,
  parameter int          WAIT_STATES  = 0,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        request_valid,
  output logic        request_ready,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  output logic        response_valid,
  output logic [31:0] read_data
`ifdef DMEM_FAULT_EN
  ,
  output logic        fault
`endif
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  dmem_state_e           state_q;
  logic                  ready_q;
  logic                  resp_q;
  logic [31:0]           read_data_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic [LANES-1:0]      mask_q;
  logic                  rd_q;
  logic                  wr_q;
`ifdef DMEM_FAULT_EN
  logic                  fault_q;
`endif

  logic                  acc_in_range;
  logic [IDX_W-1:0]      acc_idx;
  logic                  rd_issue;
  logic [IDX_W-1:0]      rd_idx;
  logic [LANES-1:0]      wr_lane_en;
  logic [31:0]           bank_rdata;

  function automatic logic in_range_fn(input logic [31:0] a);
    logic [31:0] offset;
    offset = a - BASE_ADDRESS;
    return (a >= BASE_ADDRESS) && ((offset >> 2) < 32'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] idx_fn(input logic [31:0] a);
    logic [31:0] offset;
    offset = a - BASE_ADDRESS;
    return IDX_W'(offset >> 2);
  endfunction

  // Bank control: the read is launched one cycle before ACCESS so the word is
  // available in ACCESS and can be aligned into the registered read_data.
  always_comb begin
    acc_in_range = in_range_fn(addr_q);
    acc_idx      = idx_fn(addr_q);
    rd_idx       = idx_fn(addr_q);
    rd_issue     = 1'b0;
    if (state_q == IDLE) begin
      rd_idx   = idx_fn(address);
      rd_issue = request_valid && (WAIT_STATES == 0);
    end else if (state_q == WAIT) begin
      rd_issue = (wait_cnt_q == '0);
    end else begin
      rd_issue = 1'b0;
    end
    // Only a genuine store (read bit clear) inside the array touches memory.
    if ((state_q == ACCESS) && wr_q && !rd_q && acc_in_range) begin
      wr_lane_en = mask_q;
    end else begin
      wr_lane_en = '0;
    end
  end

  dmem_sram_bank #(
    .DEPTH(DEPTH)
  ) u_bank (
    .clk       (clk),
    .wr_en_i   (wr_lane_en),
    .wr_idx_i  (acc_idx),
    .wr_data_i (wdata_q),
    .rd_en_i   (rd_issue),
    .rd_idx_i  (rd_idx),
    .rd_data_o (bank_rdata)
  );

  // Responder FSM with registered handshake, data and fault outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      resp_q      <= 1'b0;
      read_data_q <= 32'h0000_0000;
      wait_cnt_q  <= '0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      mask_q      <= 4'b0000;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
`ifdef DMEM_FAULT_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      resp_q  <= 1'b0;
`ifdef DMEM_FAULT_EN
      fault_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (request_valid) begin
            addr_q  <= address;
            wdata_q <= write_data;
            mask_q  <= write_mask;
            rd_q    <= memory_read;
            wr_q    <= memory_write;
            ready_q <= 1'b0;
            if (WAIT_STATES > 0) begin
              state_q    <= WAIT;
              wait_cnt_q <= WAIT_INIT;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        WAIT: begin
          if (wait_cnt_q == '0) begin
            state_q <= ACCESS;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
          end
        end
        ACCESS: begin
          state_q <= RESP;
          resp_q  <= 1'b1;
          if (rd_q) begin
            read_data_q <= acc_in_range ? align_right(bank_rdata, addr_q[1:0])
                                        : 32'h0000_0000;
          end else if (!wr_q) begin
            read_data_q <= 32'h0000_0000;
          end else begin
            read_data_q <= read_data_q;
          end
`ifdef DMEM_FAULT_EN
          fault_q <= ((rd_q || wr_q) && !acc_in_range)
                   || (wr_q && !rd_q && (mask_q == 4'b0000))
                   || (!rd_q && !wr_q);
`endif
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign request_ready  = ready_q;
  assign response_valid = resp_q;
  assign read_data      = read_data_q;
`ifdef DMEM_FAULT_EN
  assign fault          = fault_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// -----------------------------------------------------------------------------
// tb_data_memory_responder
// Two responders share one request bus: instance 0 has no wait states and
// base 0, instance 1 has three wait states and base 0x40. A reference model
// (word arrays plus held read value) predicts every response.
// -----------------------------------------------------------------------------
module tb_data_memory_responder;

  localparam int          DEPTH = 64;
  localparam int          WS0   = 0;
  localparam int          WS1   = 3;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        ready_s [2];
  logic        resp_s [2];
  logic [31:0] rdata_s [2];
  logic        fault_s [2];

  int          checks   = 0;
  int          failures = 0;

  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] last_rd [2];
  int          ws_m [2];
  logic [31:0] base_m [2];
  logic [31:0] obs_rd [2];

  always #5 clk = ~clk;

  data_memory_responder #(
    .DEPTH(DEPTH), .WAIT_STATES(WS0), .BASE_ADDRESS(BASE0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .request_valid(req_valid[0]),
    .request_ready(ready_s[0]), .memory_read(mem_read),
    .memory_write(mem_write), .address(addr), .write_data(wdata),
    .write_mask(wmask), .response_valid(resp_s[0]), .read_data(rdata_s[0])
`ifdef DMEM_FAULT_EN
    , .fault(fault_s[0])
`endif
  );

  data_memory_responder #(
    .DEPTH(DEPTH), .WAIT_STATES(WS1), .BASE_ADDRESS(BASE1)
  ) u_dut1 (
    .clk(clk), .reset(reset), .request_valid(req_valid[1]),
    .request_ready(ready_s[1]), .memory_read(mem_read),
    .memory_write(mem_write), .address(addr), .write_data(wdata),
    .write_mask(wmask), .response_valid(resp_s[1]), .read_data(rdata_s[1])
`ifdef DMEM_FAULT_EN
    , .fault(fault_s[1])
`endif
  );

`ifndef DMEM_FAULT_EN
  assign fault_s[0] = 1'b0;
  assign fault_s[1] = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Issue one request to both instances at a negedge; optionally assert reset
  // at negedge rst_at after the accept edge. Returns at a negedge.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] m, input int rst_at);
    logic [31:0] exp_rd [2];
    logic        exp_f [2];
    logic        aborted [2];
    int          resp_k [2];
    int          resp_cnt [2];
    int          ready_bad [2];
    logic        obs_f [2];
    for (int i = 0; i < 2; i++) begin
      logic [31:0] off;
      logic        inr;
      int          idx;
      aborted[i] = (rst_at != 0) && (rst_at <= 1 + ws_m[i]);
      off = a - base_m[i];
      inr = (a >= base_m[i]) && ((off >> 2) < DEPTH);
      idx = inr ? int'(off >> 2) : 0;
      if (rd) begin
        exp_rd[i] = inr ? (mem_m[i][idx] >> (8 * int'(a[1:0]))) : 32'h0;
        exp_f[i]  = !inr;
        if (!aborted[i]) last_rd[i] = exp_rd[i];
      end else if (wr) begin
        exp_rd[i] = last_rd[i];
        exp_f[i]  = !inr || (m == 4'b0000);
        if (inr && !aborted[i]) begin
          for (int l = 0; l < 4; l++) begin
            if (m[l]) mem_m[i][idx][8*l +: 8] = d[8*l +: 8];
          end
        end
      end else begin
        exp_rd[i] = 32'h0;
        exp_f[i]  = 1'b1;
        if (!aborted[i]) last_rd[i] = 32'h0;
      end
      if (aborted[i]) last_rd[i] = 32'h0;
      resp_k[i] = 0; resp_cnt[i] = 0; ready_bad[i] = 0;
      obs_rd[i] = 32'h0; obs_f[i] = 1'b0;
      check_eq($sformatf("ready_before_req%0d", i), {31'h0, ready_s[i]}, 32'h1);
    end
    mem_read = rd; mem_write = wr; addr = a; wdata = d; wmask = m;
    req_valid[0] = 1'b1; req_valid[1] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (resp_s[i]) begin
          resp_cnt[i]++;
          if (resp_k[i] == 0) begin
            resp_k[i] = k; obs_rd[i] = rdata_s[i]; obs_f[i] = fault_s[i];
          end
        end
        if (!aborted[i] && (k <= 2 + ws_m[i]) && ready_s[i]) ready_bad[i]++;
        if (k == 2 + ws_m[i]) req_valid[i] = 1'b0;
      end
      if (k == 1) begin
        mem_read = 1'($urandom); mem_write = 1'($urandom);
        addr = $urandom; wdata = $urandom; wmask = 4'($urandom);
      end
      if (rst_at != 0 && k == rst_at) begin
        reset = 1'b1; req_valid[0] = 1'b0; req_valid[1] = 1'b0;
      end
      if (rst_at != 0 && k == rst_at + 1) reset = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (aborted[i]) begin
        check_eq($sformatf("no_resp_after_reset%0d", i), resp_cnt[i], 0);
      end else begin
        check_eq($sformatf("latency%0d", i), resp_k[i], 2 + ws_m[i]);
        check_eq($sformatf("single_pulse%0d", i), resp_cnt[i], 1);
        check_eq($sformatf("ready_low_busy%0d", i), ready_bad[i], 0);
        check_eq($sformatf("read_data%0d@%08h", i, a), obs_rd[i], exp_rd[i]);
`ifdef DMEM_FAULT_EN
        check_eq($sformatf("fault%0d@%08h", i, a), {31'h0, obs_f[i]}, {31'h0, exp_f[i]});
`endif
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    ws_m[0] = WS0; ws_m[1] = WS1;
    base_m[0] = BASE0; base_m[1] = BASE1;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'h0; wdata = 32'h0; wmask = 4'h0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_ready%0d", i), {31'h0, ready_s[i]}, 32'h1);
      check_eq($sformatf("rst_resp%0d", i), {31'h0, resp_s[i]}, 32'h0);
      check_eq($sformatf("rst_rdata%0d", i), rdata_s[i], 32'h0);
      check_eq($sformatf("rst_fault%0d", i), {31'h0, fault_s[i]}, 32'h0);
    end

    // Preload every word of both arrays so the model starts fully known.
    for (int a = 0; a < 32'h140; a += 4) begin
      do_req(1'b0, 1'b1, 32'(a), $urandom, 4'b1111, 0);
    end

    // Full-word store then load.
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 0);
    check_eq("lw_deadbeef", obs_rd[0], 32'hDEADBEEF);

    // Byte store into lane 2.
    do_req(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b1111, 0);
    do_req(1'b0, 1'b1, 32'h12, 32'h5A5A5A5A, 4'b0100, 0);
    do_req(1'b1, 1'b0, 32'h12, 32'h0, 4'b0000, 0);
    check_eq("lb_0x12", obs_rd[0], 32'h0000115A);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 0);
    check_eq("lw_after_sb", obs_rd[0], 32'h115A3344);

    // Half-word store into the upper half.
    do_req(1'b0, 1'b1, 32'h20, 32'h0, 4'b1111, 0);
    do_req(1'b0, 1'b1, 32'h22, 32'hBEEFBEEF, 4'b1100, 0);
    do_req(1'b1, 1'b0, 32'h20, 32'h0, 4'b0000, 0);
    check_eq("lw_after_sh", obs_rd[0], 32'hBEEF0000);
    do_req(1'b1, 1'b0, 32'h22, 32'h0, 4'b0000, 0);
    check_eq("lh_0x22", obs_rd[0], 32'h0000BEEF);

    // Out of range, empty mask, read+write both set, no-op.
    do_req(1'b1, 1'b0, 32'(4 * DEPTH), 32'h0, 4'b0000, 0);
    check_eq("oor_read0", obs_rd[0], 32'h0);
    do_req(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0);
    do_req(1'b0, 1'b1, 32'h8, 32'h12345678, 4'b1111, 0);
    do_req(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 4'b1111, 0);
    do_req(1'b0, 1'b0, 32'h8, 32'h0, 4'b1111, 0);
    do_req(1'b1, 1'b0, 32'h10, 32'h0, 4'b0000, 0);
    check_eq("mask0_unchanged", obs_rd[0], 32'h115A3344);

    // Reset during instance 1's WAIT of a store; instance 0 completes first.
    do_req(1'b0, 1'b1, 32'h50, 32'h0BADF00D, 4'b1111, 2);
    @(negedge clk);
    do_req(1'b1, 1'b0, 32'h50, 32'h0, 4'b0000, 0);

    // Randomized traffic checked against the model.
    for (int n = 0; n < 150; n++) begin
      do_req(1'($urandom), 1'($urandom), 32'($urandom_range(0, 32'h15F)),
             $urandom, 4'($urandom), 0);
    end

    // Word readback across both address windows.
    for (int a = 0; a < 32'h140; a += 4) begin
      do_req(1'b1, 1'b0, 32'(a), 32'h0, 4'b0000, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
